// File: rtl/seq_comparator_msb.sv
// rtl/seq_comparator_msb.sv - multi-cycle MSB-first unsigned magnitude comparator with early exit
module seq_comparator_msb #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_A_G_B,
    output logic             out_A_E_B,
    output logic             out_A_L_B,
    output logic             busy
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        flags_q, flags_d;  // {G, E, L}
    logic [DIGIT-1:0]  dig_a, dig_b;

    assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
    assign dig_b = b_q[idx_q*DIGIT +: DIGIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IDX_TOP;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Exit on the first unequal digit; equality needs every digit scanned.
                if (dig_a > dig_b) begin
                    flags_d = 3'b100;
                    state_d = S_DONE;
                end else if (dig_a < dig_b) begin
                    flags_d = 3'b001;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    flags_d = 3'b010;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_A_G_B = flags_q[2];
        out_A_E_B = flags_q[1];
        out_A_L_B = flags_q[0];
    end
endmodule
